core_run_ctrl: RTL and testbench

Run/stall sequencer for the single-cycle core. Watches the current instruction fields and the external input handshake, and drives one clock-enable that gates both the PC update and the register-file write. It provides start/stop/single-step control, stalls on `IN` reads until data is valid, detects the halt idiom (unconditional branch with offset 0), keeps a retired-instruction counter and optionally a PC breakpoint.

---
 rtl/core_run_ctrl.sv | 158 +++++++++++++++
 tb/tb_core_run_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/core_run_ctrl.sv
// -----------------------------------------------------------------------------
// core_run_ctrl
//   Run/stall sequencer for the single-cycle core. Produces one clock-enable
//   (core_en) that gates both the PC update and the register-file write.
//   Supports start/stop/single-step, stalls on IN reads until in_valid,
//   detects the halt idiom (unconditional branch with CONST == 0), counts
//   retired instructions (saturating) and optionally stops at a PC breakpoint.
//
//   Optional feature macro: CORE_RUN_CTRL_BREAKPOINT_EN
//     defined   -> PC breakpoint with one-shot skip after a resume
//     undefined -> no breakpoint logic; pc, bp_addr and bp_valid are unused
//
//   Ports
//     clk, reset      clock, synchronous active-high reset
//     start/stop/step run control (stop > start > step)
//     pc              current core PC
//     instr_b         instruction B field (unconditional branch)
//     instr_ws        instruction WS field (1 = IN)
//     instr_const     instruction CONST field
//     in_valid        external IN data valid
//     in_ready        IN consumed this cycle (combinational)
//     core_en         PC / regfile write enable this cycle (combinational)
//     state           IDLE=0, RUN=1, WAIT_IN=2, HALT=3 (registered)
//     halted          high while in HALT (registered)
//     retired         count of core_en cycles, saturating
//     bp_addr         breakpoint PC
//     bp_valid        breakpoint armed
// -----------------------------------------------------------------------------
module core_run_ctrl #(
  parameter int PC_W  = 8,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             step,
  input  logic [PC_W-1:0]  pc,
  input  logic             instr_b,
  input  logic [1:0]       instr_ws,
  input  logic [7:0]       instr_const,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             core_en,
  output logic [1:0]       state,
  output logic             halted,
  output logic [CNT_W-1:0] retired,
  input  logic [PC_W-1:0]  bp_addr,
  input  logic             bp_valid
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_WAIT_IN = 2'd2,
    S_HALT    = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic             halted_q;
  logic [CNT_W-1:0] retired_q;
  logic             exec_en;
  logic             start_run;
  logic             bp_hit;

  // Instruction decode terms.
  logic halt_instr, needs_in, can_exec;
  assign halt_instr = instr_b & (instr_const == 8'd0);
  assign needs_in   = (instr_ws == 2'd1);
  assign can_exec   = ~halt_instr & (~needs_in | in_valid);

  // Leaving IDLE through start (stop has priority).
  assign start_run  = (state_q == S_IDLE) & ~stop & start;

`ifdef CORE_RUN_CTRL_BREAKPOINT_EN
  // skip_bp lets a resume at the breakpoint PC execute that instruction once.
  logic skip_bp_q, skip_bp_d;

  assign bp_hit = bp_valid & (pc == bp_addr) & ~skip_bp_q;

  always_comb begin
    skip_bp_d = skip_bp_q;
    if (start_run)    skip_bp_d = 1'b1;
    else if (core_en) skip_bp_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) skip_bp_q <= 1'b0;
    else       skip_bp_q <= skip_bp_d;
  end
`else
  assign bp_hit = 1'b0;
  logic unused_bp;
  assign unused_bp = &{1'b0, pc, bp_addr, bp_valid};
`endif

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    exec_en = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (stop) begin
          state_d = S_IDLE;
        end else if (start) begin
          state_d = S_RUN;
        end else if (step) begin
          if (halt_instr)    state_d = S_HALT;
          else if (can_exec) exec_en = 1'b1;
          // step on an IN read without data is ignored
        end
      end
      S_RUN: begin
        if (stop)                      state_d = S_IDLE;
        else if (halt_instr)           state_d = S_HALT;
        else if (bp_hit)               state_d = S_IDLE;
        else if (needs_in & ~in_valid) state_d = S_WAIT_IN;
        else                           exec_en = 1'b1;
      end
      S_WAIT_IN: begin
        if (stop) begin
          state_d = S_IDLE;
        end else if (in_valid) begin
          exec_en = 1'b1;
          state_d = S_RUN;
        end
      end
      S_HALT: begin
        if (stop) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Reset masks the Mealy outputs in the same cycle it is asserted.
  assign core_en  = exec_en & ~reset;
  assign in_ready = core_en & needs_in;

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      halted_q  <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q  <= state_d;
      halted_q <= (state_d == S_HALT);
      if (core_en && (retired_q != {CNT_W{1'b1}}))
        retired_q <= retired_q + 1'b1;
    end
  end

  assign state   = state_q;
  assign halted  = halted_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_core_run_ctrl.sv
// -----------------------------------------------------------------------------
// tb_core_run_ctrl
//   Self-checking bench for core_run_ctrl: directed scenarios followed by
//   randomized stimulus, every cycle compared against a behavioural model.
// -----------------------------------------------------------------------------
module tb_core_run_ctrl;

`ifdef CORE_RUN_CTRL_BREAKPOINT_EN
  localparam bit BP_EN = 1'b1;
`else
  localparam bit BP_EN = 1'b0;
`endif

  localparam int PC_W  = 8;
  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0, stop = 1'b0, step = 1'b0;
  logic [PC_W-1:0]  pc = '0;
  logic             instr_b = 1'b0;
  logic [1:0]       instr_ws = 2'd0;
  logic [7:0]       instr_const = 8'd1;
  logic             in_valid = 1'b0;
  logic             in_ready, core_en, halted;
  logic [1:0]       state;
  logic [CNT_W-1:0] retired;
  logic [PC_W-1:0]  bp_addr = 8'd5;
  logic             bp_valid = 1'b0;

  core_run_ctrl #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .step(step),
    .pc(pc), .instr_b(instr_b), .instr_ws(instr_ws), .instr_const(instr_const),
    .in_valid(in_valid), .in_ready(in_ready), .core_en(core_en),
    .state(state), .halted(halted), .retired(retired),
    .bp_addr(bp_addr), .bp_valid(bp_valid)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: mode 0..3 = idle, run, waiting for input, halted.
  int              m_mode = 0;
  longint unsigned m_ret  = 0;
  bit              m_skip = 1'b0;
  logic            last_en, last_rdy;

  // One clock cycle with the currently driven inputs: compare at the
  // falling edge, then advance the model across the rising edge.
  task automatic tick();
    bit en, is_halt, wants_in, runnable, bp, resume;
    int nxt;
    @(negedge clk);
    is_halt  = instr_b && (instr_const == 8'd0);
    wants_in = (instr_ws == 2'd1);
    runnable = !is_halt && (!wants_in || in_valid);
    bp       = BP_EN && bp_valid && (pc == bp_addr) && !m_skip;
    en = 1'b0; nxt = m_mode; resume = 1'b0;
    if (m_mode == 0) begin
      if (stop)       ;
      else if (start) begin nxt = 1; resume = 1'b1; end
      else if (step && is_halt)  nxt = 3;
      else if (step && runnable) en = 1'b1;
    end else if (m_mode == 1) begin
      if (stop || bp)                nxt = 0;
      else if (is_halt)              nxt = 3;
      else if (wants_in && !in_valid) nxt = 2;
      else                           en = 1'b1;
    end else if (m_mode == 2) begin
      if (stop)          nxt = 0;
      else if (in_valid) begin en = 1'b1; nxt = 1; end
    end else begin
      if (stop) nxt = 0;
    end
    if (reset) en = 1'b0;

    last_en  = core_en;
    last_rdy = in_ready;
    check("core_en",  core_en,  en);
    check("in_ready", in_ready, en && wants_in);
    check("state",    state,    m_mode[1:0]);
    check("halted",   halted,   m_mode == 3);
    check("retired",  retired,  m_ret);

    @(posedge clk);
    if (reset) begin
      m_mode = 0; m_ret = 0; m_skip = 1'b0;
    end else begin
      m_mode = nxt;
      if (en && m_ret < 64'hFFFF_FFFF) m_ret++;
      if (resume)  m_skip = 1'b1;
      else if (en) m_skip = 1'b0;
    end
    #1;
  endtask

  task automatic plain_instr();
    instr_b = 1'b0; instr_const = 8'd3; instr_ws = 2'd0; in_valid = 1'b0;
    start = 1'b0; stop = 1'b0; step = 1'b0;
  endtask

  logic [CNT_W-1:0] ret_snap;

  initial begin
    plain_instr();
    #1;
    // Reset, then run a program without IN reads.
    reset = 1'b1; tick(); tick();
    reset = 1'b0; start = 1'b1; tick();
    check("start_cycle_en", last_en, 1'b0);
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      pc = 8'(i); tick();
      check("run_en", last_en, 1'b1);
    end
    check("retired_after_5", retired, 5);

    // Stall on IN for 3 cycles, then data arrives.
    instr_ws = 2'd1; in_valid = 1'b0;
    tick(); tick(); tick();
    check("wait_state", state, 2);
    in_valid = 1'b1; tick();
    check("wait_release_en", last_en, 1'b1);
    check("wait_release_rdy", last_rdy, 1'b1);
    check("back_to_run", state, 1);

    // Halt idiom, start ignored, stop returns to IDLE.
    plain_instr(); instr_b = 1'b1; instr_const = 8'd0;
    tick();
    check("halt_en", last_en, 1'b0);
    check("halted_reg", halted, 1'b1);
    ret_snap = retired;
    start = 1'b1; tick();
    check("halt_start_ignored", state, 3);
    start = 1'b0; stop = 1'b1; tick();
    check("halt_stop_idle", state, 0);
    check("halt_retired_same", retired, ret_snap);

    // Single step.
    plain_instr(); ret_snap = retired;
    step = 1'b1; tick();
    check("step_en", last_en, 1'b1);
    step = 1'b0; tick();
    check("step_once", last_en, 1'b0);
    check("step_retired", retired, ret_snap + 1);
    instr_ws = 2'd1; in_valid = 1'b0; step = 1'b1; tick();
    check("step_ignored_en", last_en, 1'b0);
    check("step_ignored_state", state, 0);

    // start and stop together stay IDLE; reset mid WAIT_IN.
    plain_instr(); start = 1'b1; stop = 1'b1; tick();
    check("start_stop_idle", state, 0);
    stop = 1'b0; tick();
    start = 1'b0; instr_ws = 2'd1; tick();
    check("wait_before_reset", state, 2);
    reset = 1'b1; in_valid = 1'b1; tick();
    check("reset_masks_en", last_en, 1'b0);
    check("reset_state", state, 0);
    check("reset_retired", retired, 0);
    reset = 1'b0; plain_instr();

    if (BP_EN) begin
      bp_addr = 8'd5; bp_valid = 1'b1; pc = 8'd3;
      start = 1'b1; tick(); start = 1'b0;
      tick();
      pc = 8'd5; tick();
      check("bp_stop_en", last_en, 1'b0);
      check("bp_stop_idle", state, 0);
      start = 1'b1; tick(); start = 1'b0;
      tick();
      check("bp_resume_en", last_en, 1'b1);
      pc = 8'd6; tick();
      check("bp_continue_en", last_en, 1'b1);
      bp_valid = 1'b0;
      stop = 1'b1; tick(); stop = 1'b0;
    end

    // Randomized stimulus against the model.
    for (int i = 0; i < 3000; i++) begin
      reset       = ($urandom % 100) == 0;
      start       = ($urandom % 8) == 0;
      stop        = ($urandom % 16) == 0;
      step        = ($urandom % 4) == 0;
      instr_b     = ($urandom % 6) == 0;
      instr_const = ($urandom % 2) ? 8'd0 : 8'($urandom);
      instr_ws    = 2'($urandom);
      in_valid    = $urandom % 2;
      pc          = 8'($urandom_range(0, 7));
      bp_valid    = $urandom % 2;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
